// File: rtl/usb_serial_in_arbiter.sv
// Round-robin, burst-bounded arbiter merging two byte streams onto one tagged IN stream.
// Optional per-channel byte counters: define USB_SERIAL_IN_ARBITER_STATS_EN.
module usb_serial_in_arbiter #(
  parameter int unsigned BURST_MAX = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [7:0]  s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [7:0]  m_data,
  output logic        m_chan,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] stat0_cnt,
  output logic [15:0] stat1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [9:0] CNT_LAST = 10'(BURST_MAX - 1);

  state_e      state_q, state_d;
  logic [9:0]  count_q, count_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_chan_q, m_chan_d;
  logic        m_valid_q, m_valid_d;
  logic        out_free_s;
  logic        acc0_s, acc1_s;

  // A source may push whenever the output slot is empty or draining this cycle.
  assign out_free_s = ~m_valid_q | m_ready;
  assign s0_ready   = (state_q == GNT0) & out_free_s;
  assign s1_ready   = (state_q == GNT1) & out_free_s;
  assign acc0_s     = s0_valid & s0_ready;
  assign acc1_s     = s1_valid & s1_ready;

  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;
  assign m_valid = m_valid_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    m_data_d     = m_data_q;
    m_chan_d     = m_chan_q;
    m_valid_d    = m_valid_q;

    if (acc0_s || acc1_s) begin
      m_data_d  = acc1_s ? s1_data : s0_data;
      m_chan_d  = acc1_s;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    // Every release passes through IDLE, which yields the one-cycle bubble.
    case (state_q)
      IDLE: begin
        if (s0_valid && (!s1_valid || last_grant_q)) begin
          state_d = GNT0;
        end else if (s1_valid) begin
          state_d = GNT1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!s0_valid || (acc0_s && (count_q == CNT_LAST))) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          count_d      = 10'd0;
        end else if (acc0_s) begin
          count_d = count_q + 10'd1;
        end else begin
          count_d = count_q;
        end
      end
      GNT1: begin
        if (!s1_valid || (acc1_s && (count_q == CNT_LAST))) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          count_d      = 10'd0;
        end else if (acc1_s) begin
          count_d = count_q + 10'd1;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      count_q      <= 10'd0;
      last_grant_q <= 1'b1;
      m_data_q     <= 8'h00;
      m_chan_q     <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      m_data_q     <= m_data_d;
      m_chan_q     <= m_chan_d;
      m_valid_q    <= m_valid_d;
    end
  end

`ifdef USB_SERIAL_IN_ARBITER_STATS_EN
  logic [15:0] stat0_q, stat1_q;

  // Free-running wrap-around counters of forwarded bytes per channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat0_q <= 16'h0000;
      stat1_q <= 16'h0000;
    end else begin
      stat0_q <= stat0_q + {15'd0, acc0_s};
      stat1_q <= stat1_q + {15'd0, acc1_s};
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`else
  assign stat0_cnt = 16'h0000;
  assign stat1_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_serial_in_arbiter.sv
// Directed bench for usb_serial_in_arbiter: streaming, alternation, backpressure, early release, reset.
module tb_usb_serial_in_arbiter;

  logic        clk;
  logic        rstn;
  logic [7:0]  s0_data;
  logic        s0_valid;
  logic        s0_ready;
  logic [7:0]  s1_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [7:0]  m_data;
  logic        m_chan;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] stat0_cnt;
  logic [15:0] stat1_cnt;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  int         s0_rem = 0;
  int         s1_rem = 0;
  logic [7:0] s0_next = 8'h00;
  logic [7:0] s1_next = 8'h80;

  int         log_cyc[$];
  logic [7:0] log_data[$];
  logic       log_chan[$];

  usb_serial_in_arbiter #(.BURST_MAX(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s0_data   (s0_data),
    .s0_valid  (s0_valid),
    .s0_ready  (s0_ready),
    .s1_data   (s1_data),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .stat0_cnt (stat0_cnt),
    .stat1_cnt (stat1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sources();
    s0_valid = (s0_rem != 0);
    s0_data  = s0_next;
    s1_valid = (s1_rem != 0);
    s1_data  = s1_next;
  endtask

  // One clock: sample handshakes before the edge, log output transfers, advance sources.
  task automatic tick();
    logic       a0, a1, o, c;
    logic [7:0] d;
    #1;
    a0 = s0_valid & s0_ready;
    a1 = s1_valid & s1_ready;
    o  = m_valid & m_ready;
    d  = m_data;
    c  = m_chan;
    @(posedge clk);
    #1;
    if (o) begin
      log_cyc.push_back(cyc);
      log_data.push_back(d);
      log_chan.push_back(c);
    end
    if (a0) begin s0_next++; s0_rem--; end
    if (a1) begin s1_next++; s1_rem--; end
    drive_sources();
    cyc++;
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    s0_rem = 0;
    s1_rem = 0;
    drive_sources();
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;
    log_cyc.delete();
    log_data.delete();
    log_chan.delete();
  endtask

  task automatic start(input int r0, input logic [7:0] b0, input int r1, input logic [7:0] b1);
    s0_rem  = r0;
    s0_next = b0;
    s1_rem  = r1;
    s1_next = b1;
    drive_sources();
  endtask

  initial begin
    rstn = 1'b1; m_ready = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = 8'h00; s1_data = 8'h00;
    #2;

    // Reset state
    rstn = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_stat0", stat0_cnt, 0);
    chk("rst_stat1", stat1_cnt, 0);

    // T1: single channel, 40 bytes, burst split after 32 with one bubble
    do_reset();
    start(40, 8'h00, 0, 8'h80);
    for (int t = 0; t < 50; t++) tick();
    chk("t1_count", log_data.size(), 40);
    for (int i = 0; i < 40; i++) begin
      chk("t1_data", log_data[i], i);
      chk("t1_chan", log_chan[i], 0);
      chk("t1_cyc", log_cyc[i], (i < 32) ? i + 2 : i + 3);
    end

    // T2/T6: both continuously valid, four alternating 32-byte bursts
    do_reset();
    start(1000, 8'h00, 1000, 8'h80);
    for (int t = 0; t < 133; t++) tick();
    chk("t2_count", log_data.size(), 128);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 32; j++) begin
        chk("t2_chan", log_chan[32*k+j], k % 2);
        chk("t2_data", log_data[32*k+j], ((k % 2) ? 32'h80 : 32'h00) + 32*(k/2) + j);
        chk("t2_cyc", log_cyc[32*k+j], 2 + 33*k + j);
      end
    end
`ifdef USB_SERIAL_IN_ARBITER_STATS_EN
    chk("t6_stat0", stat0_cnt, 64);
    chk("t6_stat1", stat1_cnt, 64);
`else
    chk("t6_stat0", stat0_cnt, 0);
    chk("t6_stat1", stat1_cnt, 0);
`endif

    // T3: 10-cycle downstream stall mid-burst
    do_reset();
    start(40, 8'h00, 0, 8'h80);
    for (int t = 0; t < 56; t++) begin
      if (t == 10) m_ready = 1'b0;
      if (t == 20) m_ready = 1'b1;
      if (t >= 10 && t < 20) begin
        #1;
        chk("t3_hold_valid", m_valid, 1);
        chk("t3_hold_data", m_data, 8);
        chk("t3_hold_chan", m_chan, 0);
        chk("t3_s0_ready", s0_ready, 0);
      end
      tick();
    end
    chk("t3_count", log_data.size(), 40);
    for (int i = 0; i < 40; i++) chk("t3_data", log_data[i], i);
    chk("t3_cyc7", log_cyc[7], 9);
    chk("t3_cyc8", log_cyc[8], 20);
    chk("t3_cyc31", log_cyc[31], 43);
    chk("t3_cyc32", log_cyc[32], 45);

    // T4: ch0 sends 5 bytes then drops, ch1 takes over
    do_reset();
    start(5, 8'h00, 1000, 8'h80);
    for (int t = 0; t < 20; t++) tick();
    chk("t4_count", log_data.size(), 16);
    for (int i = 0; i < 5; i++) begin
      chk("t4_ch0_data", log_data[i], i);
      chk("t4_ch0_chan", log_chan[i], 0);
      chk("t4_ch0_cyc", log_cyc[i], i + 2);
    end
    chk("t4_ch1_data", log_data[5], 32'h80);
    chk("t4_ch1_chan", log_chan[5], 1);
    chk("t4_ch1_cyc", log_cyc[5], 9);

    // T5: asynchronous reset mid-burst, then ch0 wins first again
    do_reset();
    start(1000, 8'h00, 1000, 8'h80);
    for (int t = 0; t < 11; t++) tick();
    chk("t5_pre_valid", m_valid, 1);
    chk("t5_pre_s0_ready", s0_ready, 1);
    rstn = 1'b0;
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_s0_ready", s0_ready, 0);
    chk("t5_s1_ready", s1_ready, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;
    log_cyc.delete();
    log_data.delete();
    log_chan.delete();
    start(1000, 8'h40, 1000, 8'hC0);
    for (int t = 0; t < 4; t++) tick();
    chk("t5_first_chan", log_chan[0], 0);
    chk("t5_first_data", log_data[0], 32'h40);
    chk("t5_first_cyc", log_cyc[0], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
